// File: rtl/round_robin_arbiter_n_pkg.sv
// Shared types and helpers for the round-robin arbiter.
package rr_arb_pkg;

  localparam int PTR_W = 5;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_t;

  // Advance an index by one, wrapping from last back to zero.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] idx,
                                               input logic [PTR_W-1:0] last);
    logic [PTR_W-1:0] nxt;
    if (idx == last) begin
      nxt = 5'd0;
    end else begin
      nxt = idx + 5'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/round_robin_arbiter_n_priority_pick.sv
// Rotating-priority scan: first set request at or after ptr, wrapping at N-1.
module rr_priority_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] index,
  output logic                 valid
);

  localparam int W = $clog2(N);
  localparam logic [W:0] N_EXT = (W+1)'(N);

  logic [W:0]   sum_s;
  logic [W-1:0] idx_s;

  // Walk the N candidates in priority order and keep the first hit.
  always_comb begin
    grant = '0;
    index = '0;
    valid = 1'b0;
    sum_s = '0;
    idx_s = '0;
    for (int k = 0; k < N; k++) begin
      sum_s = {1'b0, ptr} + (W+1)'(k);
      if (sum_s >= N_EXT) begin
        idx_s = W'(sum_s - N_EXT);
      end else begin
        idx_s = W'(sum_s);
      end
      if (!valid && req[idx_s]) begin
        grant[idx_s] = 1'b1;
        index        = idx_s;
        valid        = 1'b1;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/round_robin_arbiter_n.sv
// N-way round-robin arbiter with zero-latency grants; optional burst hold
// enabled by defining ROUND_ROBIN_ARBITER_N_HOLD_EN.
module round_robin_arbiter_n #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         requests,
  output logic [N-1:0]         grants,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_id
);

  import rr_arb_pkg::*;

  localparam int W = $clog2(N);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N - 1);

  if (N < 2 || N > 32 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_param
    $error("round_robin_arbiter_n: N must be 2..32 and MAX_HOLD 1..255");
  end

  logic [W-1:0] ptr_r;
  logic [N-1:0] pick_grant_s;
  logic [W-1:0] pick_index_s;
  logic         pick_valid_s;
  logic [W-1:0] ptr_next_s;

  rr_priority_pick #(.N(N)) u_pick (
    .req   (requests),
    .ptr   (ptr_r),
    .grant (pick_grant_s),
    .index (pick_index_s),
    .valid (pick_valid_s)
  );

  // Whoever is granted this cycle hands top priority to its successor.
  always_comb begin
    ptr_next_s = W'(ptr_inc(PTR_W'(grant_id), LAST_IDX));
  end

`ifdef ROUND_ROBIN_ARBITER_N_HOLD_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_HOLD);

  arb_state_t     state_r;
  logic [W-1:0]   owner_r;
  logic [CNT_W-1:0] cnt_r;
  logic           hold_s;

  // Burst continues only if the owner was granted last cycle and still asks.
  always_comb begin
    hold_s = (state_r == ARB_HOLD) && (cnt_r < MAX_CNT) && requests[owner_r];
  end

  // Owner bypasses the scan during a burst; otherwise the scan decides.
  always_comb begin
    grants      = '0;
    grant_id    = '0;
    grant_valid = 1'b0;
    if (hold_s) begin
      grants[owner_r] = 1'b1;
      grant_id        = owner_r;
      grant_valid     = 1'b1;
    end else begin
      grants      = pick_grant_s;
      grant_id    = pick_index_s;
      grant_valid = pick_valid_s;
    end
  end

  // Pointer, owner and burst length; an idle cycle ends any burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r   <= '0;
      owner_r <= '0;
      cnt_r   <= '0;
      state_r <= ARB_IDLE;
    end else if (grant_valid) begin
      ptr_r   <= ptr_next_s;
      state_r <= ARB_HOLD;
      if (hold_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        owner_r <= grant_id;
        cnt_r   <= CNT_W'(1);
      end
    end else begin
      state_r <= ARB_IDLE;
    end
  end
`else
  // Plain per-cycle round robin.
  always_comb begin
    grants      = pick_grant_s;
    grant_id    = pick_index_s;
    grant_valid = pick_valid_s;
  end

  // Pointer moves only on cycles that grant someone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (grant_valid) begin
      ptr_r <= ptr_next_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end
`endif

endmodule

// File: tb/tb_round_robin_arbiter_n.sv
// Directed bench for round_robin_arbiter_n (N=4/MAX_HOLD=3 and N=2/MAX_HOLD=1).
module tb_round_robin_arbiter_n;

  logic       clk;
  logic       rst_n;
  logic [3:0] req4;
  logic [3:0] gnt4;
  logic       gv4;
  logic [1:0] gid4;
  logic [1:0] req2;
  logic [1:0] gnt2;
  logic       gv2;
  logic       gid2;

  int n_checks = 0;
  int n_fail   = 0;

  round_robin_arbiter_n #(.N(4), .MAX_HOLD(3)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .requests(req4),
    .grants(gnt4), .grant_valid(gv4), .grant_id(gid4)
  );

  round_robin_arbiter_n #(.N(2), .MAX_HOLD(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .requests(req2),
    .grants(gnt2), .grant_valid(gv2), .grant_id(gid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] id_of4(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req4  = 4'b0000;
    req2  = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req4 = 4'b1111;
    req2 = 2'b11;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (gnt4 !== 4'b0001) begin
        n_fail++; $display("FAIL reset_grants4 got=%b exp=0001", gnt4);
      end
      n_checks++;
      if (gv4 !== 1'b1 || gid4 !== 2'd0) begin
        n_fail++; $display("FAIL reset_id4 got=%b/%0d exp=1/0", gv4, gid4);
      end
      n_checks++;
      if (gnt2 !== 2'b01) begin
        n_fail++; $display("FAIL reset_grants2 got=%b exp=01", gnt2);
      end
      @(posedge clk);
      #1;
    end
    req4 = 4'b0000;
    #1;
    n_checks++;
    if (gnt4 !== 4'b0000 || gv4 !== 1'b0 || gid4 !== 2'd0) begin
      n_fail++; $display("FAIL reset_idle got=%b/%b/%0d exp=0000/0/0", gnt4, gv4, gid4);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] ex [7];
`ifdef ROUND_ROBIN_ARBITER_N_HOLD_EN
    ex = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
`else
    ex = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
`endif
    do_reset();
    for (int k = 0; k < 7; k++) begin
      req4 = 4'b1111;
      #1;
      n_checks++;
      if (gnt4 !== ex[k] || gv4 !== 1'b1 || gid4 !== id_of4(ex[k])) begin
        n_fail++;
        $display("FAIL rr_all step %0d got=%b/%b/%0d exp=%b/1/%0d",
                 k, gnt4, gv4, gid4, ex[k], id_of4(ex[k]));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_owner_drop();
    logic [3:0] rq [5];
    logic [3:0] ex [5];
    rq = '{4'b0010, 4'b1101, 4'b1101, 4'b1101, 4'b1101};
`ifdef ROUND_ROBIN_ARBITER_N_HOLD_EN
    ex = '{4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b1000};
`else
    ex = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0100};
`endif
    do_reset();
    for (int k = 0; k < 5; k++) begin
      req4 = rq[k];
      #1;
      n_checks++;
      if (gnt4 !== ex[k] || gid4 !== id_of4(ex[k])) begin
        n_fail++;
        $display("FAIL owner_drop step %0d got=%b/%0d exp=%b/%0d",
                 k, gnt4, gid4, ex[k], id_of4(ex[k]));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] rq [5];
    logic [3:0] ex [5];
    rq = '{4'b0100, 4'b0000, 4'b0101, 4'b0000, 4'b0101};
    ex = '{4'b0100, 4'b0000, 4'b0001, 4'b0000, 4'b0100};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      req4 = rq[k];
      #1;
      n_checks++;
      if (gnt4 !== ex[k] || gv4 !== (|ex[k]) || gid4 !== id_of4(ex[k])) begin
        n_fail++;
        $display("FAIL wrap step %0d got=%b/%b/%0d exp=%b/%b/%0d",
                 k, gnt4, gv4, gid4, ex[k], |ex[k], id_of4(ex[k]));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [3:0] after2;
`ifdef ROUND_ROBIN_ARBITER_N_HOLD_EN
    after2 = 4'b0001;
`else
    after2 = 4'b0010;
`endif
    do_reset();
    for (int k = 0; k < 2; k++) begin
      req4 = 4'b0100;
      #1;
      n_checks++;
      if (gnt4 !== 4'b0100) begin
        n_fail++; $display("FAIL mid_burst_setup %0d got=%b exp=0100", k, gnt4);
      end
      @(negedge clk);
    end
    rst_n = 1'b0;
    req4  = 4'b1111;
    #1;
    n_checks++;
    if (gnt4 !== 4'b0001) begin
      n_fail++; $display("FAIL mid_burst_in_reset got=%b exp=0001", gnt4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (gnt4 !== 4'b0001) begin
      n_fail++; $display("FAIL mid_burst_release got=%b exp=0001", gnt4);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (gnt4 !== after2) begin
      n_fail++; $display("FAIL mid_burst_next got=%b exp=%b", gnt4, after2);
    end
    @(negedge clk);
  endtask

  task automatic test_n2();
    logic [1:0] rq [10];
    logic [1:0] ex [10];
    rq = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b11};
    ex = '{2'b01, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b01};
    do_reset();
    for (int k = 0; k < 10; k++) begin
      req2 = rq[k];
      #1;
      n_checks++;
      if (gnt2 !== ex[k] || gv2 !== (|ex[k]) || gid2 !== ex[k][1]) begin
        n_fail++;
        $display("FAIL n2 step %0d got=%b/%b/%0d exp=%b/%b/%0d",
                 k, gnt2, gv2, gid2, ex[k], |ex[k], ex[k][1]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req4  = 4'b0000;
    req2  = 2'b00;
    test_reset();
    test_round_robin();
    test_owner_drop();
    test_wrap();
    test_reset_mid_burst();
    test_n2();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/round_robin_arbiter_n.md
ROUND_ROBIN_ARBITER_N -- requirements
Module: round_robin_arbiter_n

Interface
REQ-001 SHALL have parameter N, default 4: number of requesters, legal range 2..32.
REQ-002 SHALL have parameter MAX_HOLD, default 4: maximum consecutive grant cycles per burst, legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port requests, input, N bits: bit i high means requester i wants a grant this cycle.
REQ-006 SHALL have port grants, output, N bits: one-hot or zero; bit i high means requester i is granted this cycle.
REQ-007 SHALL have port grant_valid, output, 1 bit: high when any grant bit is high.
REQ-008 SHALL have port grant_id, output, $clog2(N) bits: index of the granted requester; 0 when grant_valid is low.

Function
REQ-009 SHALL compute grants combinationally from requests and registered state in the same cycle (zero latency).
REQ-010 SHALL keep a priority pointer ptr; arbitration scans ptr, ptr+1, ... N-1, 0, ... ptr-1 and grants the first set request bit.
REQ-011 SHALL set ptr to (i+1) mod N on every edge where requester i is granted; ptr SHALL be unchanged on edges with no grant.
REQ-012 SHALL grant no requester and leave all state unchanged when requests is all zero.
REQ-013 SHALL never assert more than one grants bit, and SHALL never grant a requester whose request bit is low.
REQ-014 SHALL track owner (last granted index) and burst count cnt (1..MAX_HOLD, width $clog2(MAX_HOLD+1)).
REQ-015 SHALL keep a hold-active condition: cnt < MAX_HOLD and requests[owner] high and the previous cycle granted owner.
REQ-016 SHALL grant owner, bypassing pointer arbitration, when hold is active; cnt SHALL then increment.
REQ-017 SHALL fall back to pointer arbitration when hold is inactive; the granted index then becomes owner and cnt is set to 1, even when the same requester wins again.
REQ-018 SHALL end the burst immediately if owner drops its request; the other requesters SHALL then be arbitrated in that same cycle, starting from owner+1.
REQ-019 SHALL wrap the pointer from N-1 to 0 with no idle cycle.
REQ-020 SHALL give no grant in a cycle where requests is zero, and the burst SHALL end.
REQ-021 SHALL behave as a pure per-cycle round robin when MAX_HOLD equals 1; for N=2 this is the two-request arbiter behaviour.

Reset
REQ-022 SHALL, while rst_n is low, clear ptr to 0, owner to 0, cnt to 0 and the hold flag to 0, independent of clk.
REQ-023 SHALL drive grants from pointer arbitration with ptr=0 during reset and after it; an active burst interrupted by reset SHALL not resume.
REQ-024 SHALL give requester 0 the highest priority in the first cycle after reset release.

Configuration
REQ-025 SHALL use macro ROUND_ROBIN_ARBITER_N_HOLD_EN to control the hold feature.
REQ-026 SHALL, when ROUND_ROBIN_ARBITER_N_HOLD_EN is defined, implement burst hold per REQ-014..REQ-018.
REQ-027 SHALL, when ROUND_ROBIN_ARBITER_N_HOLD_EN is not defined, omit owner, cnt and the hold flag, and behave as if MAX_HOLD were 1; the MAX_HOLD parameter remains and is ignored.

Structure
REQ-028 SHALL use package rr_arb_pkg to hold the arbiter state enum (ARB_IDLE, ARB_HOLD) and the function that computes the pointer increment with wrap.
REQ-029 SHALL use a combinational sub-module rr_priority_pick (params N; inputs req, ptr; outputs one-hot grant, index, valid) for the rotating priority scan.
REQ-030 SHALL check parameter legality with an elaboration-time assertion.

Verification (N=4, MAX_HOLD=3 unless stated)
REQ-031 SHALL cover reset mid-burst: owner 2 at cnt=2, pull rst_n low, requests=1111 -> grants=0001 immediately, then 0001 on the next cycle after release (new burst).
REQ-032 SHALL cover hold disabled with requests=1111 held for 5 cycles -> grants 0001,0010,0100,1000,0001.
REQ-033 SHALL cover hold enabled with requests=1111 held for 7 cycles -> grants 0001,0001,0001,0010,0010,0010,0100.
REQ-034 SHALL cover owner dropping its request: owner 1 granted, then requests=1101 -> grants 0100 in that same cycle, with cnt=1.
REQ-035 SHALL cover sparse requests with wrap: ptr=3, requests=0101 -> grants 0001, then ptr=1 and requests=0101 -> grants 0100 (hold disabled).
REQ-036 SHALL cover N=2, MAX_HOLD=1: requests 01,00,10,11,11,00,11,00,11,11 -> grants 01,00,10,01,10,00,01,00,10,01.
